// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix multiplier result path.
package matrix_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, WRITE, DONE} writer_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width that stays legal (>=1 bit) when the range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_N        = 2;
  localparam int DEF_M        = 2;
  localparam int DEF_LINE_LEN = 2;
  localparam int ROW_CNT_W    = cnt_w(DEF_N);
  localparam int COL_CNT_W    = cnt_w(DEF_M);
  localparam int WORD_CNT_W   = cnt_w(DEF_LINE_LEN);

endpackage

// File: rtl/result_line_packer.sv
// Line buffer: collects result elements into word slots with a per-word valid mask.
module result_line_packer
  import matrix_pkg::*;
#(
  parameter int LINE_LEN    = 2,
  parameter int ACCUM_WIDTH = 16,
  parameter int IDX_W       = cnt_w(LINE_LEN)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [IDX_W-1:0]                idx,
  input  logic [ACCUM_WIDTH-1:0]          din,
  input  logic                            clear,
  output logic [LINE_LEN*ACCUM_WIDTH-1:0] line_data,
  output logic [LINE_LEN-1:0]             line_mask,
  output logic                            full
);

  // Loading the last slot completes the line.
  assign full = (idx == IDX_W'(LINE_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_data <= '0;
      line_mask <= '0;
    end else if (clear) begin
      line_data <= '0;
      line_mask <= '0;
    end else if (load) begin
      for (int k = 0; k < LINE_LEN; k++) begin
        if (idx == IDX_W'(k)) begin
          line_data[k*ACCUM_WIDTH +: ACCUM_WIDTH] <= din;
          line_mask[k]                            <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_result_writer.sv
// Drains row-major result elements from the multiplier FIFO and writes them to result RAM in lines.
module matrix_result_writer
  import matrix_pkg::*;
#(
  parameter int N           = 2,
  parameter int M           = 2,
  parameter int LINE_LEN    = 2,
  parameter int ACCUM_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ACCUM_WIDTH-1:0]          fifo_head,
  input  logic                            fifo_empty,
  output logic                            pop_fifo,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [LINE_LEN*ACCUM_WIDTH-1:0] wr_data,
  output logic [LINE_LEN-1:0]             wr_mask,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int LINES_PER_ROW = ceil_div(M, LINE_LEN);
  localparam int ROW_W         = cnt_w(N);
  localparam int COL_W         = cnt_w(M);
  localparam int WORD_W        = cnt_w(LINE_LEN);
  localparam int LINE_W        = cnt_w(LINES_PER_ROW);

  writer_state_t             state_q, state_d;
  logic [ROW_W-1:0]          row_q;
  logic [COL_W-1:0]          col_q;
  logic [WORD_W-1:0]         word_q;
  logic [LINE_W-1:0]         line_q;
  logic                      row_end_q;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic                      err_q;

  logic accept, drain_pop, close, hs, last_line, line_full, active, stray;

  assign active    = (state_q == DRAIN) || (state_q == WRITE);
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign drain_pop = (state_q == DRAIN) && !fifo_empty;
  // A line closes on its last slot or at the end of a row; rows never share a line.
  assign close     = drain_pop && (line_full || (col_q == COL_W'(M - 1)));
  assign hs        = (state_q == WRITE) && wr_ready;
  assign last_line = row_end_q && (row_q == ROW_W'(N - 1));
  assign stray     = !fifo_empty && ((state_q == IDLE) || (state_q == DONE));
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop_fifo = 1'b0;
    wr_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        pop_fifo = drain_pop;
        if (close) state_d = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        if (wr_ready) state_d = last_line ? DONE : DRAIN;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      word_q    <= '0;
      line_q    <= '0;
      row_end_q <= 1'b0;
      base_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        base_q    <= base_addr;
        row_q     <= '0;
        col_q     <= '0;
        word_q    <= '0;
        line_q    <= '0;
        row_end_q <= 1'b0;
        err_q     <= 1'b0;
      end else if ((start && active) || stray) begin
        err_q <= 1'b1;
      end

      if (drain_pop) begin
        row_end_q <= (col_q == COL_W'(M - 1));
        if (col_q != COL_W'(M - 1)) col_q <= col_q + COL_W'(1);
        if (!close) word_q <= word_q + WORD_W'(1);
      end

      if (hs) begin
        word_q <= '0;
        if (row_end_q) begin
          row_q     <= row_q + ROW_W'(1);
          col_q     <= '0;
          line_q    <= '0;
          row_end_q <= 1'b0;
        end else begin
          line_q <= line_q + LINE_W'(1);
        end
      end
    end
  end

  // Line address wraps naturally at ADDR_WIDTH bits.
  assign wr_addr = (state_q == WRITE)
                 ? base_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(LINES_PER_ROW) + ADDR_WIDTH'(line_q)
                 : '0;

  result_line_packer #(
    .LINE_LEN    (LINE_LEN),
    .ACCUM_WIDTH (ACCUM_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (drain_pop),
    .idx       (word_q),
    .din       (fifo_head),
    .clear     (hs),
    .line_data (wr_data),
    .line_mask (wr_mask),
    .full      (line_full)
  );

endmodule

// File: tb/tb_matrix_result_writer.sv
// Scoreboard bench for matrix_result_writer: a 2x2 instance and a 1x3 partial-line instance.
module tb_matrix_result_writer;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LL = 2;
  localparam int LW = LL * DW;

  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic [LL-1:0] m;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          start, fifo_empty, pop_fifo, wr_valid, wr_ready, busy, done, err;
  logic [AW-1:0] base_addr, wr_addr;
  logic [DW-1:0] fifo_head;
  logic [LW-1:0] wr_data;
  logic [LL-1:0] wr_mask;

  logic          start_p, fifo_empty_p, pop_fifo_p, wr_valid_p, wr_ready_p, busy_p, done_p, err_p;
  logic [AW-1:0] base_addr_p, wr_addr_p;
  logic [DW-1:0] fifo_head_p;
  logic [LW-1:0] wr_data_p;
  logic [LL-1:0] wr_mask_p;

  matrix_result_writer #(.N(2), .M(2), .LINE_LEN(LL), .ACCUM_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .fifo_head(fifo_head), .fifo_empty(fifo_empty), .pop_fifo(pop_fifo),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .busy(busy), .done(done), .err(err)
  );

  matrix_result_writer #(.N(1), .M(3), .LINE_LEN(LL), .ACCUM_WIDTH(DW), .ADDR_WIDTH(AW)) dut_p (
    .clk(clk), .rst_n(rst_n), .start(start_p), .base_addr(base_addr_p),
    .fifo_head(fifo_head_p), .fifo_empty(fifo_empty_p), .pop_fifo(pop_fifo_p),
    .wr_valid(wr_valid_p), .wr_ready(wr_ready_p), .wr_addr(wr_addr_p), .wr_data(wr_data_p),
    .wr_mask(wr_mask_p), .busy(busy_p), .done(done_p), .err(err_p)
  );

  wr_t           exp_q[$];
  wr_t           exp_p[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] fifo_pq[$];
  int  checks = 0, failures = 0, cyc = 0, pops = 0, pops_p = 0, hs_cyc = 0, gap_cnt = 0, vcnt = 0;
  bit  fifo_en = 0, fifo_en_p = 0, gap_mode = 0, bp_mode = 0, ready_block = 0, held = 0;
  wr_t held_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic wr_t mk(input logic [AW-1:0] a, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                             input logic [LL-1:0] m);
    wr_t w;
    w.a = a;
    w.d = {hi, lo};
    w.m = m;
    return w;
  endfunction

  // Environment + monitor for the 2x2 instance: FIFO model, ready shaping, write scoreboard.
  initial begin
    wr_t e;
    fifo_empty = 1'b1;
    fifo_head  = '0;
    wr_ready   = 1'b0;
    forever begin
      @(negedge clk);
      if (!fifo_en || fifo_q.size() == 0 || gap_cnt > 0) begin
        fifo_empty = 1'b1;
        if (gap_cnt > 0) gap_cnt--;
      end else begin
        fifo_empty = 1'b0;
        fifo_head  = fifo_q[0];
      end
      wr_ready = !ready_block && (!bp_mode || vcnt >= 3);
      #1;
      if (pop_fifo) begin
        chk(!fifo_empty, "pop_while_empty", pop_fifo, 0);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pops++;
        if (gap_mode) gap_cnt = $urandom_range(0, 5);
      end
      if (wr_valid) begin
        chk(pop_fifo == 1'b0, "pop_during_write", pop_fifo, 0);
        if (held)
          chk(wr_addr == held_w.a && wr_data == held_w.d && wr_mask == held_w.m,
              "stall_stable", wr_data, held_w.d);
        if (wr_ready) begin
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_write", wr_addr, 0);
          end else begin
            e = exp_q.pop_front();
            chk(wr_addr == e.a, "wr_addr", wr_addr, e.a);
            chk(wr_data == e.d, "wr_data", wr_data, e.d);
            chk(wr_mask == e.m, "wr_mask", wr_mask, e.m);
          end
          held   = 0;
          vcnt   = 0;
          hs_cyc = cyc;
        end else begin
          held     = 1;
          held_w.a = wr_addr;
          held_w.d = wr_data;
          held_w.m = wr_mask;
          vcnt++;
        end
      end else begin
        held = 0;
      end
    end
  end

  // Environment + monitor for the partial-line instance.
  initial begin
    wr_t e;
    fifo_empty_p = 1'b1;
    fifo_head_p  = '0;
    wr_ready_p   = 1'b1;
    forever begin
      @(negedge clk);
      fifo_empty_p = !(fifo_en_p && fifo_pq.size() > 0);
      if (!fifo_empty_p) fifo_head_p = fifo_pq[0];
      #1;
      if (pop_fifo_p && fifo_pq.size() > 0) begin
        void'(fifo_pq.pop_front());
        pops_p++;
      end
      if (wr_valid_p && wr_ready_p) begin
        if (exp_p.size() == 0) begin
          chk(0, "p_unexpected_write", wr_addr_p, 0);
        end else begin
          e = exp_p.pop_front();
          chk(wr_addr_p == e.a, "p_wr_addr", wr_addr_p, e.a);
          chk(wr_data_p == e.d, "p_wr_data", wr_data_p, e.d);
          chk(wr_mask_p == e.m, "p_wr_mask", wr_mask_p, e.m);
        end
      end
    end
  end

  task automatic load4(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input logic [DW-1:0] d);
    fifo_q.push_back(a);
    fifo_q.push_back(b);
    fifo_q.push_back(c);
    fifo_q.push_back(d);
  endtask

  task automatic kick(input logic [AW-1:0] b);
    pops      = 0;
    base_addr = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    fifo_en = 1'b1;
  endtask

  task automatic wait_done(input int exp_pops, input string tag);
    int k;
    k = 0;
    while (!done && k < 300) begin
      chk(busy == 1'b1, {tag, "_busy"}, busy, 1);
      @(posedge clk); #1;
      k++;
    end
    chk(done == 1'b1, {tag, "_done_timeout"}, done, 1);
    chk(cyc == hs_cyc + 1, {tag, "_done_latency"}, cyc, hs_cyc + 1);
    chk(pops == exp_pops, {tag, "_pop_count"}, pops, exp_pops);
    chk(exp_q.size() == 0, {tag, "_writes_left"}, exp_q.size(), 0);
    chk(busy == 1'b0, {tag, "_busy_after_done"}, busy, 0);
    fifo_en = 1'b0;
  endtask

  initial begin
    int k;
    start = 1'b0; base_addr = '0; start_p = 1'b0; base_addr_p = '0;
    #1 rst_n = 1'b0;
    #2;
    chk(wr_valid == 1'b0, "rst_wr_valid", wr_valid, 0);
    chk(pop_fifo == 1'b0, "rst_pop_fifo", pop_fifo, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(done == 1'b0, "rst_done", done, 0);
    chk(err == 1'b0, "rst_err", err, 0);
    chk(wr_addr == '0, "rst_wr_addr", wr_addr, 0);
    chk(wr_data == '0, "rst_wr_data", wr_data, 0);
    chk(wr_mask == '0, "rst_wr_mask", wr_mask, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 2x2 result
    load4(19, 22, 43, 50);
    exp_q.push_back(mk(8'h10, 22, 19, 2'b11));
    exp_q.push_back(mk(8'h11, 50, 43, 2'b11));
    kick(8'h10);
    wait_done(4, "basic");

    // Write backpressure: three stalled cycles per line
    bp_mode = 1;
    load4(19, 22, 43, 50);
    exp_q.push_back(mk(8'h10, 22, 19, 2'b11));
    exp_q.push_back(mk(8'h11, 50, 43, 2'b11));
    kick(8'h10);
    wait_done(4, "backpressure");
    bp_mode = 0;

    // FIFO starvation with random gaps; base at top of address space wraps
    gap_mode = 1;
    gap_cnt  = 2;
    load4(19, 22, 43, 50);
    exp_q.push_back(mk(8'hFF, 22, 19, 2'b11));
    exp_q.push_back(mk(8'h00, 50, 43, 2'b11));
    kick(8'hFF);
    wait_done(4, "starve");
    gap_mode = 0;
    gap_cnt  = 0;

    // Start while busy is ignored but flagged
    load4(1, 2, 3, 4);
    exp_q.push_back(mk(8'h20, 2, 1, 2'b11));
    exp_q.push_back(mk(8'h21, 4, 3, 2'b11));
    kick(8'h20);
    base_addr = 8'h55;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk(err == 1'b1, "err_start_busy", err, 1);
    wait_done(4, "err_xfer");
    chk(err == 1'b1, "err_sticky", err, 1);

    // Start from DONE clears done and err
    load4(5, 6, 7, 8);
    exp_q.push_back(mk(8'h30, 6, 5, 2'b11));
    exp_q.push_back(mk(8'h31, 8, 7, 2'b11));
    kick(8'h30);
    chk(err == 1'b0, "err_cleared", err, 0);
    chk(done == 1'b0, "done_cleared", done, 0);
    wait_done(4, "restart");

    // Reset while a write is pending
    ready_block = 1;
    load4(19, 22, 43, 50);
    exp_q.push_back(mk(8'h10, 22, 19, 2'b11));
    kick(8'h10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!wr_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk(wr_valid == 1'b1, "reach_write", wr_valid, 1);
    chk(err == 1'b1, "err_before_reset", err, 1);
    rst_n = 1'b0;
    #1;
    chk(wr_valid == 1'b0, "rstw_wr_valid", wr_valid, 0);
    chk(busy == 1'b0, "rstw_busy", busy, 0);
    chk(done == 1'b0, "rstw_done", done, 0);
    chk(err == 1'b0, "rstw_err", err, 0);
    chk(wr_mask == '0, "rstw_wr_mask", wr_mask, 0);
    fifo_q.delete();
    exp_q.delete();
    fifo_en     = 0;
    ready_block = 0;
    held        = 0;
    vcnt        = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load4(9, 10, 11, 12);
    exp_q.push_back(mk(8'h40, 10, 9, 2'b11));
    exp_q.push_back(mk(8'h41, 12, 11, 2'b11));
    kick(8'h40);
    wait_done(4, "post_reset");

    // Stray element while DONE
    fifo_q.push_back(16'd77);
    fifo_en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk(err == 1'b1, "err_stray", err, 1);
    chk(pop_fifo == 1'b0, "stray_no_pop", pop_fifo, 0);
    fifo_en = 0;
    fifo_q.delete();

    // Partial line: 1x3 result in 2-word lines
    fifo_pq.push_back(16'd1);
    fifo_pq.push_back(16'd2);
    fifo_pq.push_back(16'd3);
    exp_p.push_back(mk(8'h00, 2, 1, 2'b11));
    exp_p.push_back(mk(8'h01, 0, 3, 2'b01));
    base_addr_p = 8'h00;
    start_p     = 1'b1;
    @(posedge clk); #1;
    start_p   = 1'b0;
    fifo_en_p = 1'b1;
    k = 0;
    while (!done_p && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(done_p == 1'b1, "p_done_timeout", done_p, 1);
    chk(pops_p == 3, "p_pop_count", pops_p, 3);
    chk(exp_p.size() == 0, "p_writes_left", exp_p.size(), 0);
    chk(err_p == 1'b0, "p_err", err_p, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
